// File: rtl/mem_io.sv
// Memory-mapped I/O block: 252-byte RAM, 16-bit free-running cycle counter
// with a coherent high-byte shadow, a synchronized switch input port and a
// registered LED output port. Read data is combinational from the address.
`timescale 1ns / 1ps
module mem_io #(
    parameter int unsigned         WIDTH   = 8,
    parameter logic [WIDTH-1:0]    RAM_TOP = 8'hFB,
    parameter logic [WIDTH-1:0]    TMR_LO  = 8'hFC,
    parameter logic [WIDTH-1:0]    TMR_HI  = 8'hFD,
    parameter logic [WIDTH-1:0]    SW_ADR  = 8'hFE,
    parameter logic [WIDTH-1:0]    LED_ADR = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] led_out
);

    localparam int unsigned RamDepth = int'(RAM_TOP) + 1;
    localparam int unsigned CntW     = 2 * WIDTH;

    logic [WIDTH-1:0] ram [RamDepth];

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [WIDTH-1:0] sw_meta_q, sw_sync_q;

    logic in_ram;
    logic wr_ram, wr_tmr_lo, wr_led, rd_tmr_lo;

    assign in_ram    = (adr <= RAM_TOP);
    // Reset blocks every write, including RAM, so a reset cycle has no side effects.
    assign wr_ram    = memwrite && in_ram && !reset;
    assign wr_tmr_lo = memwrite && (adr == TMR_LO);
    assign wr_led    = memwrite && (adr == LED_ADR);
    assign rd_tmr_lo = memread && (adr == TMR_LO);

    // RAM write port; contents are not touched by reset
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[adr] <= writedata;
        end
    end

    // Next-state for counter, shadow and LED register
    always_comb begin
        cnt_d    = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
        shadow_d = shadow_q;
        led_d    = led_q;
        if (wr_tmr_lo) begin
            cnt_d = '0;
        end
        // Capture the pre-increment high byte so the low/high pair stays coherent.
        if (rd_tmr_lo) begin
            shadow_d = cnt_q[CntW-1:WIDTH];
        end
        if (wr_led) begin
            led_d = writedata;
        end
    end

    // State registers with synchronous reset taking priority over all updates
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            shadow_q  <= '0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            led_q     <= led_d;
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign led_out = led_q;

    // Combinational read mux; one region decoded per address
    always_comb begin
        memdata = '0;
        if (in_ram) begin
            memdata = ram[adr];
        end else if (adr == TMR_LO) begin
            memdata = cnt_q[WIDTH-1:0];
        end else if (adr == TMR_HI) begin
            memdata = shadow_q;
        end else if (adr == SW_ADR) begin
            memdata = sw_sync_q;
        end else if (adr == LED_ADR) begin
            memdata = led_q;
        end
    end

endmodule

// File: tb/tb_mem_io.sv
// Directed self-checking bench for mem_io.
`timescale 1ns / 1ps
module tb_mem_io;

    logic       clk;
    logic       reset;
    logic       memread;
    logic       memwrite;
    logic [7:0] adr;
    logic [7:0] writedata;
    logic [7:0] memdata;
    logic [7:0] sw_in;
    logic [7:0] led_out;

    int checks = 0;
    int errors = 0;

    mem_io dut (
        .clk       (clk),
        .reset     (reset),
        .memread   (memread),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata),
        .memdata   (memdata),
        .sw_in     (sw_in),
        .led_out   (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then move off the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Set a read address and sample memdata once it settles
    task automatic rd(input logic [7:0] a, input string tag, input logic [7:0] exp);
        adr = a;
        #1;
        check(tag, memdata, exp);
    endtask

    initial begin
        reset = 1'b1; memread = 1'b0; memwrite = 1'b0;
        adr = 8'h00; writedata = 8'h00; sw_in = 8'h00;
        tick(); tick();

        // Reset state
        check("rst_led", led_out, 8'h00);
        rd(8'hFC, "rst_cnt_lo", 8'h00);
        rd(8'hFD, "rst_shadow", 8'h00);
        rd(8'hFE, "rst_sw", 8'h00);
        rd(8'hFF, "rst_led_rd", 8'h00);
        reset = 1'b0;

        // RAM write then read, then read-during-write
        adr = 8'h10; writedata = 8'hA5; memwrite = 1'b1;
        tick();
        memwrite = 1'b0; memread = 1'b1;
        rd(8'h10, "ram_rd", 8'hA5);
        memwrite = 1'b1; writedata = 8'h3C;
        rd(8'h10, "ram_rdw_old", 8'hA5);
        tick();
        memwrite = 1'b0; memread = 1'b0;
        rd(8'h10, "ram_rdw_new", 8'h3C);

        // LED write
        adr = 8'hFF; writedata = 8'h5A; memwrite = 1'b1;
        tick();
        memwrite = 1'b0;
        check("led_wr", led_out, 8'h5A);
        rd(8'hFF, "led_rd", 8'h5A);

        // Writes to the switch port and shadow are ignored
        adr = 8'hFE; writedata = 8'h33; memwrite = 1'b1;
        tick();
        memwrite = 1'b0;
        check("sw_wr_led", led_out, 8'h5A);
        rd(8'hFE, "sw_wr_sw", 8'h00);
        rd(8'h10, "sw_wr_ram", 8'h3C);
        adr = 8'hFD; writedata = 8'h77; memwrite = 1'b1;
        tick();
        memwrite = 1'b0;
        rd(8'hFD, "hi_wr_ign", 8'h00);

        // Reset blocks RAM write, clears LED, keeps RAM contents
        adr = 8'h20; writedata = 8'h11; memwrite = 1'b1;
        tick();
        reset = 1'b1; writedata = 8'h99;
        tick();
        reset = 1'b0; memwrite = 1'b0;
        rd(8'h20, "rst_ram_keep", 8'h11);
        check("rst_led_clr", led_out, 8'h00);
        rd(8'hFC, "rst_cnt_clr", 8'h00);

        // Switch synchronizer latency
        adr = 8'hFE; sw_in = 8'h81;
        rd(8'hFE, "sw_edge0", 8'h00);
        tick();
        rd(8'hFE, "sw_edge1", 8'h00);
        tick();
        rd(8'hFE, "sw_edge2", 8'h81);

        // Counter after 300 cycles, with high-byte snapshot
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (300) tick();
        rd(8'hFC, "cnt300_lo", 8'h2C);
        memread = 1'b1;
        tick();
        memread = 1'b0;
        rd(8'hFD, "cnt300_hi", 8'h01);
        rd(8'hFC, "cnt301_lo", 8'h2D);

        // Reset beats clear and snapshot on the same edge
        adr = 8'hFC; writedata = 8'hFF; memwrite = 1'b1; memread = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; memwrite = 1'b0; memread = 1'b0;
        rd(8'hFC, "rst_pri_lo", 8'h00);
        rd(8'hFD, "rst_pri_hi", 8'h00);
        tick();
        rd(8'hFC, "post_rst_1", 8'h01);

        // Clear alone
        repeat (5) tick();
        rd(8'hFC, "pre_clr", 8'h06);
        memwrite = 1'b1;
        tick();
        memwrite = 1'b0;
        rd(8'hFC, "clr_0", 8'h00);
        tick();
        rd(8'hFC, "clr_1", 8'h01);

        // Wrap: clear, 65535 edges to 16'hFFFF, one more to 16'h0000
        adr = 8'hFC; memwrite = 1'b1;
        tick();
        memwrite = 1'b0;
        repeat (65535) tick();
        rd(8'hFC, "wrap_lo_ff", 8'hFF);
        memread = 1'b1;
        tick();
        memread = 1'b0;
        rd(8'hFC, "wrap_lo_00", 8'h00);
        rd(8'hFD, "wrap_hi_ff", 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
